// File: rtl/cnn_conv_7x7_sched_pkg.sv
// Shared definitions for the 7x7 convolution layer scheduler.
//   - Default conv_7x7 layer dimensions.
//   - Scheduler FSM state encoding.
//   - Helpers for derived counts (weights per output channel, pixels per
//     pass) and for counter widths.
package cnn_conv_7x7_sched_pkg;

   localparam int CONV_DATA_WIDTH      = 32;
   localparam int CONV_CHANNEL_NUM_IN  = 3;
   localparam int CONV_CHANNEL_NUM_OUT = 64;
   localparam int CONV_KERNEL          = 7;
   localparam int CONV_IMAGE_SIZE      = 50176;
   localparam int CONV_RESULT_NUM      = 12544;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_W = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_NEXT   = 3'd4,
      S_FIN    = 3'd5
   } sched_state_t;

   // Weights needed by the conv core for one output channel.
   function automatic int w_num(input int kernel, input int ch_in);
      return kernel * kernel * ch_in;
   endfunction

   // Pixels streamed through the pipeline for one output channel.
   function automatic int p_num(input int image_size, input int ch_in);
      return image_size * ch_in;
   endfunction

   // Counter width able to hold the terminal count itself.
   function automatic int cnt_w(input int term);
      return $clog2(term) + 1;
   endfunction

   // Index width; a single channel still needs one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cnn_conv_7x7_sched_gate.sv
// Ready/valid-to-strobe register stage with an accept counter.
// Handshake: a word is accepted in a cycle where valid_in && enable; the
// accepted word appears on data_out with valid_out high on the next cycle.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   enable         ready presented to the source this cycle
//   clear          zero the accept counter (wins over an accept)
//   valid_in       source word valid
//   data_in        source word
//   valid_out      registered strobe, one cycle after each accept
//   data_out       registered word (holds between strobes)
//   last           accept of the final word (counter == TERM-1), combinational
module cnn_sched_gate #(
   parameter int DATA_WIDTH = 32,
   parameter int TERM       = 9,
   parameter int CNT_W      = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  clear,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  valid_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  last
);

   logic             accept;
   logic [CNT_W-1:0] cnt;

   assign accept = valid_in & enable;
   assign last   = accept && (cnt == CNT_W'(TERM - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         cnt       <= '0;
      end else begin
         valid_out <= accept;
         if (accept) data_out <= data_in;
         if (clear)       cnt <= '0;
         else if (accept) cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/cnn_conv_7x7_sched.sv
// Scheduler for the 7x7 convolution pipeline. For each output channel it
// loads the kernel weights into the conv core, streams the whole input image
// into the loop-data block, then waits for all results of that channel.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      begin a layer run (only honoured in IDLE)
//   weight_valid_in/weight_in  weight source; weight_ready accepts
//   pxl_valid_in/pxl_in        pixel source; pxl_ready accepts
//   valid_weight_out/weight_out  weight strobe to conv core
//   valid_pxl_out/pxl_out      pixel strobe to loop-data block
//   result_valid               channel adder output valid (counted only)
//   och_idx                    current output channel
//   busy                       not IDLE
//   done                       one-cycle pulse at end of the layer
//   err                        sticky: result_valid seen in IDLE or LOAD_W
module cnn_conv_7x7_sched
   import cnn_conv_7x7_sched_pkg::*;
#(
   parameter int DATA_WIDTH      = CONV_DATA_WIDTH,
   parameter int CHANNEL_NUM_IN  = CONV_CHANNEL_NUM_IN,
   parameter int CHANNEL_NUM_OUT = CONV_CHANNEL_NUM_OUT,
   parameter int KERNEL          = CONV_KERNEL,
   parameter int IMAGE_SIZE      = CONV_IMAGE_SIZE,
   parameter int RESULT_NUM      = CONV_RESULT_NUM
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic                              weight_valid_in,
   input  logic [DATA_WIDTH-1:0]             weight_in,
   output logic                              weight_ready,
   input  logic                              pxl_valid_in,
   input  logic [DATA_WIDTH-1:0]             pxl_in,
   output logic                              pxl_ready,
   output logic                              valid_weight_out,
   output logic [DATA_WIDTH-1:0]             weight_out,
   output logic                              valid_pxl_out,
   output logic [DATA_WIDTH-1:0]             pxl_out,
   input  logic                              result_valid,
   output logic [idx_w(CHANNEL_NUM_OUT)-1:0] och_idx,
   output logic                              busy,
   output logic                              done,
   output logic                              err
);

   localparam int W_NUM   = w_num(KERNEL, CHANNEL_NUM_IN);
   localparam int P_NUM   = p_num(IMAGE_SIZE, CHANNEL_NUM_IN);
   localparam int W_CNT_W = cnt_w(W_NUM);
   localparam int P_CNT_W = cnt_w(P_NUM);
   localparam int R_CNT_W = cnt_w(RESULT_NUM);
   localparam int OCH_W   = idx_w(CHANNEL_NUM_OUT);

   sched_state_t       state, state_next;
   logic [R_CNT_W-1:0] r_cnt;
   logic               start_acc;
   logic               w_last, p_last;
   logic               stray_result;
   logic               count_result;
   logic               r_full;
   logic               och_last;

   assign start_acc    = (state == S_IDLE) && start;
   assign r_full       = (r_cnt == R_CNT_W'(RESULT_NUM));
   assign och_last     = (och_idx == OCH_W'(CHANNEL_NUM_OUT - 1));
   assign stray_result = result_valid && ((state == S_IDLE) || (state == S_LOAD_W));
   assign count_result = result_valid && !r_full &&
                         ((state == S_STREAM) || (state == S_DRAIN));

   cnn_sched_gate #(
      .DATA_WIDTH (DATA_WIDTH),
      .TERM       (W_NUM),
      .CNT_W      (W_CNT_W)
   ) u_weight_gate (
      .clk       (clk),
      .reset     (reset),
      .enable    (weight_ready),
      .clear     (start_acc | w_last),
      .valid_in  (weight_valid_in),
      .data_in   (weight_in),
      .valid_out (valid_weight_out),
      .data_out  (weight_out),
      .last      (w_last)
   );

   // Pixel count is kept until NEXT so it reads as "pass complete" in DRAIN.
   cnn_sched_gate #(
      .DATA_WIDTH (DATA_WIDTH),
      .TERM       (P_NUM),
      .CNT_W      (P_CNT_W)
   ) u_pxl_gate (
      .clk       (clk),
      .reset     (reset),
      .enable    (pxl_ready),
      .clear     (start_acc | (state == S_NEXT)),
      .valid_in  (pxl_valid_in),
      .data_in   (pxl_in),
      .valid_out (valid_pxl_out),
      .data_out  (pxl_out),
      .last      (p_last)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next   = state;
      weight_ready = 1'b0;
      pxl_ready    = 1'b0;
      busy         = (state != S_IDLE);
      done         = 1'b0;
      case (state)
         S_IDLE:   if (start) state_next = S_LOAD_W;
         S_LOAD_W: begin
            weight_ready = 1'b1;
            if (w_last) state_next = S_STREAM;
         end
         S_STREAM: begin
            pxl_ready = 1'b1;
            if (p_last) state_next = S_DRAIN;
         end
         S_DRAIN:  if (r_full) state_next = S_NEXT;
         S_NEXT:   state_next = och_last ? S_FIN : S_LOAD_W;
         S_FIN: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         och_idx <= '0;
         r_cnt   <= '0;
         err     <= 1'b0;
      end else begin
         if (start_acc)                          och_idx <= '0;
         else if ((state == S_NEXT) && !och_last) och_idx <= och_idx + OCH_W'(1);

         if (start_acc || (state == S_NEXT)) r_cnt <= '0;
         else if (count_result)              r_cnt <= r_cnt + R_CNT_W'(1);

         // A stray result in the same cycle as start still flags the new run.
         if (stray_result)   err <= 1'b1;
         else if (start_acc) err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cnn_conv_7x7_sched.sv
// Directed bench for cnn_conv_7x7_sched with a small layer:
// 1 input channel, 2 output channels, 3x3 kernel (9 weights),
// 16 pixels per pass, 4 results per output channel.
module tb_cnn_conv_7x7_sched;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          weight_valid_in;
   logic [DW-1:0] weight_in;
   logic          weight_ready;
   logic          pxl_valid_in;
   logic [DW-1:0] pxl_in;
   logic          pxl_ready;
   logic          valid_weight_out;
   logic [DW-1:0] weight_out;
   logic          valid_pxl_out;
   logic [DW-1:0] pxl_out;
   logic          result_valid;
   logic [0:0]    och_idx;
   logic          busy;
   logic          done;
   logic          err;

   logic [DW-1:0] w_exp_q[$];
   logic [DW-1:0] p_exp_q[$];

   int vectors     = 0;
   int miscompares = 0;
   int w_strobes   = 0;
   int p_strobes   = 0;
   int done_cnt    = 0;

   always #5 clk = ~clk;

   cnn_conv_7x7_sched #(
      .DATA_WIDTH      (DW),
      .CHANNEL_NUM_IN  (1),
      .CHANNEL_NUM_OUT (2),
      .KERNEL          (3),
      .IMAGE_SIZE      (16),
      .RESULT_NUM      (4)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .weight_valid_in  (weight_valid_in),
      .weight_in        (weight_in),
      .weight_ready     (weight_ready),
      .pxl_valid_in     (pxl_valid_in),
      .pxl_in           (pxl_in),
      .pxl_ready        (pxl_ready),
      .valid_weight_out (valid_weight_out),
      .weight_out       (weight_out),
      .valid_pxl_out    (valid_pxl_out),
      .pxl_out          (pxl_out),
      .result_valid     (result_valid),
      .och_idx          (och_idx),
      .busy             (busy),
      .done             (done),
      .err              (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: record accepts for the coming edge, then check the strobes
   // that edge must produce.
   task automatic step();
      logic wacc, pacc;
      wacc = !reset && weight_valid_in && weight_ready;
      pacc = !reset && pxl_valid_in && pxl_ready;
      if (wacc) w_exp_q.push_back(weight_in);
      if (pacc) p_exp_q.push_back(pxl_in);
      @(posedge clk);
      #1;
      check("ready_excl", 32'(weight_ready & pxl_ready), 0);
      check("w_strobe", 32'(valid_weight_out), 32'(wacc));
      check("p_strobe", 32'(valid_pxl_out), 32'(pacc));
      if (valid_weight_out === 1'b1) begin
         w_strobes++;
         check("w_q_nonempty", 32'(w_exp_q.size() > 0), 1);
         if (w_exp_q.size() > 0) check("w_data", weight_out, w_exp_q.pop_front());
      end
      if (valid_pxl_out === 1'b1) begin
         p_strobes++;
         check("p_q_nonempty", 32'(p_exp_q.size() > 0), 1);
         if (p_exp_q.size() > 0) check("p_data", pxl_out, p_exp_q.pop_front());
      end
      if (done === 1'b1) done_cnt++;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
      check("start_busy", 32'(busy), 1);
      check("start_wready", 32'(weight_ready), 1);
      check("start_och", 32'(och_idx), 0);
   endtask

   task automatic load_weights(input bit toggle, input logic [31:0] base,
                               input int stray_at, input logic [31:0] exp_och);
      int sent, guard, ws0;
      sent  = 0;
      guard = 0;
      ws0   = w_strobes;
      while (sent < 9 && guard < 60) begin
         weight_valid_in = toggle ? (guard % 2 == 0) : 1'b1;
         weight_in       = base + sent;
         result_valid    = (guard == stray_at);
         if (weight_valid_in && weight_ready) sent++;
         step();
         guard++;
      end
      weight_valid_in = 1'b0;
      result_valid    = 1'b0;
      check("w_accepts", sent, 9);
      check("w_strobe_cnt", w_strobes - ws0, 9);
      check("w_last_data", weight_out, base + 8);
      check("w_och", 32'(och_idx), exp_och);
      check("p_ready_after_w", 32'(pxl_ready), 1);
   endtask

   task automatic stream_pixels(input logic [15:0] rmask);
      int sent, guard, ps0;
      sent  = 0;
      guard = 0;
      ps0   = p_strobes;
      while (sent < 16 && guard < 60) begin
         pxl_valid_in = 1'b1;
         pxl_in       = $urandom;
         result_valid = rmask[sent];
         check("w_ready_in_stream", 32'(weight_ready), 0);
         if (pxl_ready) sent++;
         step();
         guard++;
      end
      pxl_valid_in = 1'b0;
      result_valid = 1'b0;
      check("p_accepts", sent, 16);
      check("p_strobe_cnt", p_strobes - ps0, 16);
      check("drain_entry", {busy, weight_ready, pxl_ready, done}, 4'b1000);
   endtask

   task automatic drain_results(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         for (int g = 0; g < gap; g++) begin
            result_valid = 1'b0;
            step();
            check("drain_gap", {busy, weight_ready, pxl_ready, done}, 4'b1000);
         end
         result_valid = 1'b1;
         step();
         result_valid = 1'b0;
         check("drain_pulse", {busy, weight_ready, pxl_ready, done}, 4'b1000);
      end
   endtask

   // Entered while DRAIN holds a full result count.
   task automatic finish_channel(input bit last_ch);
      step();
      check("next_state", {busy, weight_ready, pxl_ready, done}, 4'b1000);
      step();
      if (last_ch) begin
         check("fin_done", 32'(done), 1);
         check("fin_busy", 32'(busy), 1);
         step();
         check("idle_done", 32'(done), 0);
         check("idle_busy", 32'(busy), 0);
      end else begin
         check("reload_wready", 32'(weight_ready), 1);
         check("reload_done", 32'(done), 0);
      end
   endtask

   initial begin
      int dc;
      reset = 1'b1; start = 1'b0; result_valid = 1'b0;
      weight_valid_in = 1'b0; weight_in = '0; pxl_valid_in = 1'b0; pxl_in = '0;
      repeat (3) step();
      check("rst_ctrl", {busy, done, err, weight_ready, pxl_ready, valid_weight_out, valid_pxl_out}, 0);
      check("rst_wout", weight_out, 0);
      check("rst_pout", pxl_out, 0);
      check("rst_och", 32'(och_idx), 0);
      reset = 1'b0;
      step();

      // Nominal run.
      do_start();
      check("a_err", 32'(err), 0);
      load_weights(1'b0, 32'h100, -1, 0);
      stream_pixels(16'h0000);
      drain_results(4, 1);
      finish_channel(1'b0);
      load_weights(1'b0, 32'h200, -1, 1);
      stream_pixels(16'h0000);
      drain_results(4, 1);
      finish_channel(1'b1);
      check("a_done_cnt", done_cnt, 1);
      check("a_och_hold", 32'(och_idx), 1);

      // Source backpressure, stray result in LOAD_W, early results.
      do_start();
      load_weights(1'b1, 32'd1, 4, 0);
      check("b_err_set", 32'(err), 1);
      stream_pixels(16'h0888);
      drain_results(1, 3);
      finish_channel(1'b0);
      load_weights(1'b0, 32'h300, -1, 1);
      stream_pixels(16'h8888);
      finish_channel(1'b1);
      check("b_err_hold", 32'(err), 1);
      check("b_done_cnt", done_cnt, 2);

      // Reset in the middle of channel 0's pixel stream.
      do_start();
      check("c_err_clr", 32'(err), 0);
      load_weights(1'b0, 32'h400, -1, 0);
      for (int i = 0; i < 7; i++) begin
         pxl_valid_in = 1'b1;
         pxl_in       = $urandom;
         step();
      end
      pxl_in = $urandom;
      reset  = 1'b1;
      step();
      reset        = 1'b0;
      pxl_valid_in = 1'b0;
      check("c_rst_busy", 32'(busy), 0);
      check("c_rst_strobes", {valid_weight_out, valid_pxl_out, pxl_ready, done}, 0);
      check("c_rst_och", 32'(och_idx), 0);
      check("c_rst_pq", p_exp_q.size(), 0);
      dc = done_cnt;
      repeat (3) step();
      check("c_no_done", done_cnt, dc);

      // Fresh run with a start pulse while draining.
      do_start();
      load_weights(1'b0, 32'h500, -1, 0);
      stream_pixels(16'h0000);
      start = 1'b1;
      step();
      start = 1'b0;
      check("d_start_ignored", {busy, weight_ready, pxl_ready, done}, 4'b1000);
      drain_results(4, 1);
      finish_channel(1'b0);
      load_weights(1'b0, 32'h600, -1, 1);
      stream_pixels(16'h0000);
      drain_results(4, 1);
      finish_channel(1'b1);
      repeat (3) step();
      check("d_done_cnt", done_cnt, 3);
      check("d_idle", 32'(busy), 0);
      check("wq_empty", w_exp_q.size(), 0);
      check("pq_empty", p_exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
